// File: rtl/gshare_predictor_if.sv
// Fetch-side and execute-side signal bundle between the gshare predictor and its pipeline.
// The master side drives the IF2/EX inputs and the predictor, as slave, answers with a prediction.
interface gshare_predictor_if #(
    parameter int GHR_WIDTH = 6
);
    logic                 stall;
    logic [31:0]          IF2_pc;
    logic                 hit;
    logic                 IF2_Branch;
    logic                 IF2_Jump;
    logic [31:0]          pc_imm;
    logic                 EX_update;
    logic                 EX_taken;
    logic                 EX_mispredict;
    logic [GHR_WIDTH-1:0] EX_index;
    logic [GHR_WIDTH-1:0] EX_ghr;
    logic                 pred_taken;
    logic [31:0]          pred_pc;
    logic [GHR_WIDTH-1:0] pred_index;
    logic [GHR_WIDTH-1:0] pred_ghr;
    logic [31:0]          br_count;
    logic [31:0]          mispred_count;

    modport master (
        output stall, IF2_pc, hit, IF2_Branch, IF2_Jump, pc_imm,
        output EX_update, EX_taken, EX_mispredict, EX_index, EX_ghr,
        input  pred_taken, pred_pc, pred_index, pred_ghr, br_count, mispred_count
    );

    modport slave (
        input  stall, IF2_pc, hit, IF2_Branch, IF2_Jump, pc_imm,
        input  EX_update, EX_taken, EX_mispredict, EX_index, EX_ghr,
        output pred_taken, pred_pc, pred_index, pred_ghr, br_count, mispred_count
    );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: a PC-xor-history indexed table of 2-bit counters,
// with a speculatively shifted global history that is repaired on mispredicts from EX.
module gshare_predictor #(
    parameter int GHR_WIDTH = 6
) (
    input logic              clk,
    input logic              rst,
    gshare_predictor_if.slave bp
);
    localparam int Depth = 1 << GHR_WIDTH;

    logic [1:0]           pht_q [Depth];
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [31:0]          brCount_q, brCount_d;
    logic [31:0]          mispredCount_q, mispredCount_d;
    logic [GHR_WIDTH-1:0] predIndex;
    logic                 predDir;
    logic                 predTaken;
    logic [1:0]           exEntry, exEntry_d;

    // Prediction path is purely combinational from the current table and history.
    always_comb begin
        predIndex = bp.IF2_pc[GHR_WIDTH+1:2] ^ ghr_q;
        predDir   = pht_q[predIndex][1];
        predTaken = bp.hit & (bp.IF2_Jump | (bp.IF2_Branch & predDir));
    end

    assign bp.pred_taken    = predTaken;
    assign bp.pred_pc       = predTaken ? bp.pc_imm : bp.IF2_pc + 32'd4;
    assign bp.pred_index    = predIndex;
    assign bp.pred_ghr      = ghr_q;
    assign bp.br_count      = brCount_q;
    assign bp.mispred_count = mispredCount_q;

    // Mispredict recovery is applied last so it overrides a same-cycle speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (bp.hit && bp.IF2_Branch && !bp.stall) begin
            ghr_d = {ghr_q[GHR_WIDTH-2:0], predDir};
        end
        if (bp.EX_update && bp.EX_mispredict) begin
            ghr_d = {bp.EX_ghr[GHR_WIDTH-2:0], bp.EX_taken};
        end

        exEntry   = pht_q[bp.EX_index];
        exEntry_d = exEntry;
        if (bp.EX_taken) begin
            if (exEntry != 2'b11) begin
                exEntry_d = exEntry + 2'd1;
            end
        end else if (exEntry != 2'b00) begin
            exEntry_d = exEntry - 2'd1;
        end

        brCount_d      = brCount_q + {31'd0, bp.EX_update};
        mispredCount_d = mispredCount_q + {31'd0, bp.EX_update & bp.EX_mispredict};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                pht_q[i] <= 2'b01;
            end
            ghr_q          <= '0;
            brCount_q      <= '0;
            mispredCount_q <= '0;
        end else begin
            if (bp.EX_update) begin
                pht_q[bp.EX_index] <= exEntry_d;
            end
            ghr_q          <= ghr_d;
            brCount_q      <= brCount_d;
            mispredCount_q <= mispredCount_d;
        end
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// Randomised scoreboard bench for gshare_predictor against a table-of-integers reference model.
module tb_gshare_predictor;
    localparam int W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gshare_predictor_if #(.GHR_WIDTH(W)) bp ();

    gshare_predictor #(.GHR_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        logic [5:0]  idx;
        logic [5:0]  ghr;
        logic [31:0] br;
        logic [31:0] mis;
    } exp_t;

    exp_t        expQ[$];
    int unsigned mPht[64];
    int unsigned mGhr;
    bit   [31:0] mBr, mMis;
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 64; i++) mPht[i] = 1;
        mGhr = 0;
        mBr  = 0;
        mMis = 0;
    endtask

    // One fetch cycle: drive inputs, predict from the model, then advance the model past the edge.
    task automatic applyStimulus(input bit pulseRst, input bit st, input bit [31:0] pc,
                                 input bit h, input bit br, input bit jp, input bit [31:0] imm,
                                 input bit u, input bit t, input bit m,
                                 input bit [5:0] ei, input bit [5:0] eg);
        exp_t        e;
        int unsigned idx;
        bit          dir;
        @(posedge clk);
        #1;
        bp.stall = st; bp.IF2_pc = pc; bp.hit = h; bp.IF2_Branch = br; bp.IF2_Jump = jp;
        bp.pc_imm = imm; bp.EX_update = u; bp.EX_taken = t; bp.EX_mispredict = m;
        bp.EX_index = ei; bp.EX_ghr = eg;
        if (pulseRst) begin
            rst = 1'b1;
            modelReset();
        end
        idx     = ((pc >> 2) ^ mGhr) % 64;
        dir     = (mPht[idx] >= 2);
        e.taken = h && (jp || (br && dir));
        e.pc    = e.taken ? imm : pc + 32'd4;
        e.idx   = 6'(idx);
        e.ghr   = 6'(mGhr);
        e.br    = mBr;
        e.mis   = mMis;
        expQ.push_back(e);
        if (pulseRst) begin
            @(negedge clk);
            #2;
            rst = 1'b0;
        end
        if (u) begin
            if (t) mPht[ei] = (mPht[ei] == 3) ? 3 : mPht[ei] + 1;
            else   mPht[ei] = (mPht[ei] == 0) ? 0 : mPht[ei] - 1;
            mBr = mBr + 1;
            if (m) mMis = mMis + 1;
        end
        if (u && m)              mGhr = ((int'(eg) << 1) | int'(t)) % 64;
        else if (h && br && !st) mGhr = ((mGhr << 1) | int'(dir)) % 64;
    endtask

    // Monitor: the predictor answers every cycle, so one expectation is consumed per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pred_taken",    32'(bp.pred_taken), 32'(e.taken));
                checkOutput("pred_pc",       bp.pred_pc,         e.pc);
                checkOutput("pred_index",    32'(bp.pred_index), 32'(e.idx));
                checkOutput("pred_ghr",      32'(bp.pred_ghr),   32'(e.ghr));
                checkOutput("br_count",      bp.br_count,        e.br);
                checkOutput("mispred_count", bp.mispred_count,   e.mis);
            end
        end
    end

    initial begin
        int waitCycles;
        bp.stall = 0; bp.IF2_pc = 0; bp.hit = 0; bp.IF2_Branch = 0; bp.IF2_Jump = 0;
        bp.pc_imm = 0; bp.EX_update = 0; bp.EX_taken = 0; bp.EX_mispredict = 0;
        bp.EX_index = 0; bp.EX_ghr = 0;
        modelReset();

        applyStimulus(1, 0, 32'h100, 0, 0, 0, 32'h80, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'h100, 1, 1, 0, 32'h80, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h200, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 32'h100, 1, 1, 0, 32'h80, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'h300, 1, 0, 1, 32'h2000, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'h300, 0, 0, 0, 0, 1, 1, 1, 5, 6'h0A);
        applyStimulus(0, 0, 32'h140, 1, 1, 0, 32'h40, 1, 1, 1, 7, 6'h0A);
        applyStimulus(0, 1, 32'h144, 1, 1, 0, 32'h44, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'hFFFFFFFC, 0, 0, 0, 32'h1234, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'h108, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 32'h100, 0, 1, 0, 32'h80, 1, 1, 1, 0, 6'h3F);
        applyStimulus(1, 0, 32'h100, 0, 0, 0, 32'h80, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'h100, 1, 1, 0, 32'h80, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
                          {$urandom_range(0, 255), 2'b00} | (32'($urandom) & 32'hFFFF0000),
                          ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 5) == 0),
                          32'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 2) == 0), 6'($urandom), 6'($urandom));
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
